// File: rtl/wbdma_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interfaces : wbdma_csr_if, wbdma_wb_if                                   |
// | Purpose    : Bus bundles for the wbdma block.                            |
// |              wbdma_csr_if - CSR bus from the csrbrg bridge.              |
// |                master = bridge side, slave = CSR target (wbdma).         |
// |                csr_a[13:0], csr_we, csr_di[31:0] -> target,              |
// |                csr_do[31:0] <- target.                                   |
// |              wbdma_wb_if  - classic Wishbone master port.                |
// |                master = wbdma, slave = interconnect/memory.              |
// |                adr/dat_o/sel/cti/we/cyc/stb -> slave,                    |
// |                dat_i/ack <- slave.                                       |
// | Revision   : 1.0  initial release                                        |
// +--------------------------------------------------------------------------+

interface wbdma_csr_if;
  logic [13:0] csr_a;
  logic        csr_we;
  logic [31:0] csr_di;
  logic [31:0] csr_do;

  modport master (output csr_a, output csr_we, output csr_di, input  csr_do);
  modport slave  (input  csr_a, input  csr_we, input  csr_di, output csr_do);
endinterface

interface wbdma_wb_if;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic [3:0]  wbm_sel_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_we_o;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_ack_i;

  modport master (
    output wbm_adr_o, output wbm_dat_o, output wbm_sel_o, output wbm_cti_o,
    output wbm_we_o,  output wbm_cyc_o, output wbm_stb_o,
    input  wbm_dat_i, input  wbm_ack_i
  );
  modport slave (
    input  wbm_adr_o, input  wbm_dat_o, input  wbm_sel_o, input  wbm_cti_o,
    input  wbm_we_o,  input  wbm_cyc_o, input  wbm_stb_o,
    output wbm_dat_i, output wbm_ack_i
  );
endinterface

`default_nettype wire

// File: rtl/wbdma.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : wbdma                                                         |
// | Purpose  : CSR-programmed Wishbone master copying a block of 32-bit      |
// |            words from SRC to DST, one read then one write per word,      |
// |            with a completion interrupt.                                  |
// | Ports    : sys_clk  - system clock                                       |
// |            sys_rst  - asynchronous active-high reset                     |
// |            csr      - CSR bus (slave modport), page csr_addr             |
// |            wb       - classic Wishbone master port                       |
// |            irq      - completion interrupt (pending & irq_en)            |
// | CSR map  : 0 SRC, 1 DST, 2 COUNT, 3 CTRL (start/irq_en/abort),           |
// |            4 STAT (pending, write 1 to clear)                            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+

module wbdma #(
  parameter logic [3:0] csr_addr = 4'h2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  wbdma_csr_if.slave  csr,
  wbdma_wb_if.master  wb,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } state_t;

  localparam logic [2:0] c_reg_src   = 3'd0;
  localparam logic [2:0] c_reg_dst   = 3'd1;
  localparam logic [2:0] c_reg_count = 3'd2;
  localparam logic [2:0] c_reg_ctrl  = 3'd3;
  localparam logic [2:0] c_reg_stat  = 3'd4;

  state_t      r_state;
  logic [29:0] r_src;
  logic [29:0] r_dst;
  logic [15:0] r_count;
  logic        r_busy;
  logic        r_irq_en;
  logic        r_pending;
  logic        r_abort;
  logic [31:0] r_buf;
  logic [31:0] r_csr_do;
  logic [29:0] r_adr;
  logic [31:0] r_dat_o;
  logic        r_we;
  logic        r_cyc;
  logic        r_stb;

  logic        w_sel;
  logic        w_wr;
  logic [2:0]  w_off;
  logic        w_wr_ctrl;
  logic        w_start;
  logic        w_abort;
  logic        w_stat_clr;
  logic        w_last;
  logic [31:0] w_rd_mux;
  logic        w_unused_addr;

  assign w_sel      = (csr.csr_a[13:10] == csr_addr);
  assign w_wr       = w_sel & csr.csr_we;
  assign w_off      = csr.csr_a[2:0];
  assign w_wr_ctrl  = w_wr && (w_off == c_reg_ctrl);
  assign w_start    = w_wr_ctrl & csr.csr_di[0];
  assign w_abort    = w_wr_ctrl & csr.csr_di[2];
  assign w_stat_clr = w_wr && (w_off == c_reg_stat) && csr.csr_di[0];
  assign w_last     = (r_count == 16'd1);
  // Address bits between the page field and the register offset are don't-care.
  assign w_unused_addr = ^csr.csr_a[9:3];

  always_comb begin
    w_rd_mux = 32'd0;
    case (w_off)
      c_reg_src:   w_rd_mux = {r_src, 2'b00};
      c_reg_dst:   w_rd_mux = {r_dst, 2'b00};
      c_reg_count: w_rd_mux = {16'd0, r_count};
      c_reg_ctrl:  w_rd_mux = {30'd0, r_irq_en, r_busy};
      c_reg_stat:  w_rd_mux = {31'd0, r_pending};
      default:     w_rd_mux = 32'd0;
    endcase
  end

  // Each bus phase (RD, WR) spends its first cycle with cyc low; that cycle
  // provides the mandatory idle-bus gap after the previous ack and is also
  // where a pending abort is honoured without starting a new bus cycle.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state   <= S_IDLE;
      r_src     <= 30'd0;
      r_dst     <= 30'd0;
      r_count   <= 16'd0;
      r_busy    <= 1'b0;
      r_irq_en  <= 1'b0;
      r_pending <= 1'b0;
      r_abort   <= 1'b0;
      r_buf     <= 32'd0;
      r_csr_do  <= 32'd0;
      r_adr     <= 30'd0;
      r_dat_o   <= 32'd0;
      r_we      <= 1'b0;
      r_cyc     <= 1'b0;
      r_stb     <= 1'b0;
    end else begin
      r_csr_do <= w_sel ? w_rd_mux : 32'd0;

      if (w_wr_ctrl) begin
        r_irq_en <= csr.csr_di[1];
      end
      // Completion below is assigned later, so it overrides a same-cycle clear.
      if (w_stat_clr) begin
        r_pending <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          r_abort <= 1'b0;
          if (w_wr) begin
            case (w_off)
              c_reg_src:   r_src   <= csr.csr_di[31:2];
              c_reg_dst:   r_dst   <= csr.csr_di[31:2];
              c_reg_count: r_count <= csr.csr_di[15:0];
              default:     ;
            endcase
          end
          if (w_start) begin
            if (r_count != 16'd0) begin
              r_busy  <= 1'b1;
              r_state <= S_RD;
            end else begin
              r_pending <= 1'b1;
            end
          end
        end

        S_RD: begin
          if (w_abort) begin
            r_abort <= 1'b1;
          end
          if (!r_cyc) begin
            if (r_abort) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_abort <= 1'b0;
            end else begin
              r_cyc <= 1'b1;
              r_stb <= 1'b1;
              r_we  <= 1'b0;
              r_adr <= r_src;
            end
          end else if (wb.wbm_ack_i) begin
            r_buf <= wb.wbm_dat_i;
            r_cyc <= 1'b0;
            r_stb <= 1'b0;
            // An aborted word that was read but not written is not counted.
            if (r_abort || w_abort) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_abort <= 1'b0;
            end else begin
              r_state <= S_WR;
            end
          end
        end

        S_WR: begin
          if (w_abort) begin
            r_abort <= 1'b1;
          end
          if (!r_cyc) begin
            if (r_abort) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_abort <= 1'b0;
            end else begin
              r_cyc   <= 1'b1;
              r_stb   <= 1'b1;
              r_we    <= 1'b1;
              r_adr   <= r_dst;
              r_dat_o <= r_buf;
            end
          end else if (wb.wbm_ack_i) begin
            r_cyc   <= 1'b0;
            r_stb   <= 1'b0;
            r_we    <= 1'b0;
            r_src   <= r_src + 30'd1;
            r_dst   <= r_dst + 30'd1;
            r_count <= r_count - 16'd1;
            if (w_last) begin
              r_state   <= S_IDLE;
              r_busy    <= 1'b0;
              r_abort   <= 1'b0;
              r_pending <= 1'b1;
            end else if (r_abort || w_abort) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
              r_abort <= 1'b0;
            end else begin
              r_state <= S_RD;
            end
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign csr.csr_do   = r_csr_do;
  assign wb.wbm_adr_o = {r_adr, 2'b00};
  assign wb.wbm_dat_o = r_dat_o;
  assign wb.wbm_sel_o = {4{r_cyc}};
  assign wb.wbm_cti_o = 3'b000;
  assign wb.wbm_we_o  = r_we;
  assign wb.wbm_cyc_o = r_cyc;
  assign wb.wbm_stb_o = r_stb;
  assign irq          = r_pending & r_irq_en;

endmodule

`default_nettype wire
